// File: rtl/qspi_phase_if.sv
// Handshake and status bundle between the AHB-side transfer controller
// and the QSPI phase sequencer.
//
// master: controller side, drives the request, config, beat_en, abort.
// slave : sequencer side, drives busy/phase/beat status and pulses.
interface qspi_phase_if #(
  parameter int DLEN_W  = 16,
  parameter int DUMMY_W = 5,
  parameter int BCNT_W  = DLEN_W + 3
);
  logic               start;
  logic               xip_mode;
  logic [1:0]         cmd_lanes;
  logic [2:0]         addr_bytes;
  logic [1:0]         addr_lanes;
  logic               mode_en;
  logic [DUMMY_W-1:0] dummy_cycles;
  logic [DLEN_W-1:0]  data_bytes;
  logic [1:0]         data_lanes;
  logic               beat_en;
  logic               abort;

  logic               busy;
  logic [2:0]         phase;
  logic               phase_start;
  logic [BCNT_W-1:0]  beat_cnt;
  logic               last_beat;
  logic               done;
  logic               aborted;

  modport master (
    output start,
    output xip_mode,
    output cmd_lanes,
    output addr_bytes,
    output addr_lanes,
    output mode_en,
    output dummy_cycles,
    output data_bytes,
    output data_lanes,
    output beat_en,
    output abort,
    input  busy,
    input  phase,
    input  phase_start,
    input  beat_cnt,
    input  last_beat,
    input  done,
    input  aborted
  );

  modport slave (
    input  start,
    input  xip_mode,
    input  cmd_lanes,
    input  addr_bytes,
    input  addr_lanes,
    input  mode_en,
    input  dummy_cycles,
    input  data_bytes,
    input  data_lanes,
    input  beat_en,
    input  abort,
    output busy,
    output phase,
    output phase_start,
    output beat_cnt,
    output last_beat,
    output done,
    output aborted
  );
endinterface

// File: rtl/qspi_phase_sequencer.sv
// Sequences one QSPI transfer through CMD/ADDR/MODE/DUMMY/DATA phases,
// counting SCLK beats per phase with per-phase lane widths (1/2/4).
//
// Ports: clk, rst (async, active high), bus (qspi_phase_if.slave):
//   in : start, xip_mode, cmd/addr/data lanes, addr_bytes, mode_en,
//        dummy_cycles, data_bytes, beat_en, abort
//   out: busy, phase, phase_start, beat_cnt, last_beat, done, aborted
module qspi_phase_sequencer #(
  parameter int DLEN_W  = 16,
  parameter int DUMMY_W = 5,
  parameter int BCNT_W  = DLEN_W + 3
) (
  input  logic        clk,
  input  logic        rst,
  qspi_phase_if.slave bus
);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_CMD   = 3'd1;
  localparam logic [2:0] PH_ADDR  = 3'd2;
  localparam logic [2:0] PH_MODE  = 3'd3;
  localparam logic [2:0] PH_DUMMY = 3'd4;
  localparam logic [2:0] PH_DATA  = 3'd5;

  typedef struct packed {
    logic               xip;
    logic [1:0]         cmd_lanes;
    logic [2:0]         addr_bytes;
    logic [1:0]         addr_lanes;
    logic               mode_en;
    logic [DUMMY_W-1:0] dummy;
    logic [DLEN_W-1:0]  data_bytes;
    logic [1:0]         data_lanes;
  } cfg_t;

  cfg_t              cfg_q;
  cfg_t              in_cfg;
  logic [2:0]        phase_q;
  logic [BCNT_W-1:0] cnt_q;
  logic              phase_start_q;
  logic              done_q;
  logic              aborted_q;

  logic [BCNT_W-1:0] cur_len;
  logic              busy;
  logic              last;
  logic [2:0]        start_nxt;
  logic [2:0]        run_nxt;

  // Lane code 11 is treated as quad, same as 10.
  function automatic logic [1:0] lane_shift(
    input logic [1:0] code
  );
    logic [1:0] s;
    s = 2'd0;
    unique case (1'b1)
      code[1]:           s = 2'd2;
      (code == 2'b01):   s = 2'd1;
      default:           s = 2'd0;
    endcase
    return s;
  endfunction

  function automatic logic [BCNT_W-1:0] len_of(
    input cfg_t       c,
    input logic [2:0] ph
  );
    logic [BCNT_W-1:0] l;
    l = '0;
    case (ph)
      PH_CMD:
        if (!c.xip)
          l = BCNT_W'(8) >> lane_shift(c.cmd_lanes);
      PH_ADDR:
        l = BCNT_W'({c.addr_bytes, 3'b000})
            >> lane_shift(c.addr_lanes);
      PH_MODE:
        if (c.mode_en)
          l = BCNT_W'(8) >> lane_shift(c.addr_lanes);
      PH_DUMMY:
        l = BCNT_W'(c.dummy);
      PH_DATA:
        l = BCNT_W'({c.data_bytes, 3'b000})
            >> lane_shift(c.data_lanes);
      default:
        l = '0;
    endcase
    return l;
  endfunction

  // First phase after 'from' with a non-zero length, or IDLE when
  // nothing remains. Scanning downwards leaves the nearest one.
  function automatic logic [2:0] next_phase(
    input cfg_t       c,
    input logic [2:0] from
  );
    logic [2:0] nxt;
    nxt = PH_IDLE;
    for (int p = 5; p >= 1; p--) begin
      if (3'(p) > from && len_of(c, 3'(p)) != '0)
        nxt = 3'(p);
    end
    return nxt;
  endfunction

  always_comb begin
    in_cfg            = '0;
    in_cfg.xip        = bus.xip_mode;
    in_cfg.cmd_lanes  = bus.cmd_lanes;
    in_cfg.addr_bytes = (bus.addr_bytes > 3'd4)
                        ? 3'd4 : bus.addr_bytes;
    in_cfg.addr_lanes = bus.addr_lanes;
    in_cfg.mode_en    = bus.mode_en;
    in_cfg.dummy      = bus.dummy_cycles;
    in_cfg.data_bytes = bus.data_bytes;
    in_cfg.data_lanes = bus.data_lanes;
  end

  always_comb begin
    cur_len   = len_of(cfg_q, phase_q);
    busy      = (phase_q != PH_IDLE);
    last      = busy && (cnt_q == cur_len - BCNT_W'(1));
    start_nxt = next_phase(in_cfg, PH_IDLE);
    run_nxt   = next_phase(cfg_q, phase_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q         <= '0;
      phase_q       <= PH_IDLE;
      cnt_q         <= '0;
      phase_start_q <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      phase_start_q <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      if (!busy) begin
        if (bus.start) begin
          cfg_q         <= in_cfg;
          phase_q       <= start_nxt;
          cnt_q         <= '0;
          phase_start_q <= (start_nxt != PH_IDLE);
          done_q        <= (start_nxt == PH_IDLE);
        end
      end else if (bus.abort) begin
        phase_q   <= PH_IDLE;
        cnt_q     <= '0;
        aborted_q <= 1'b1;
      end else if (bus.beat_en) begin
        if (last) begin
          phase_q       <= run_nxt;
          cnt_q         <= '0;
          phase_start_q <= (run_nxt != PH_IDLE);
          done_q        <= (run_nxt == PH_IDLE);
        end else begin
          cnt_q <= cnt_q + BCNT_W'(1);
        end
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.phase       = phase_q;
  assign bus.phase_start = phase_start_q;
  assign bus.beat_cnt    = cnt_q;
  assign bus.last_beat   = last;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_qspi_phase_sequencer.sv
// Directed bench for qspi_phase_sequencer: transfer table with
// hand-computed phase lengths plus abort / async reset sequences.
module tb_qspi_phase_sequencer;

  localparam int DLEN_W  = 16;
  localparam int DUMMY_W = 5;
  localparam int BCNT_W  = DLEN_W + 3;

  typedef struct {
    logic        xip;
    logic [1:0]  cl;
    logic [2:0]  ab;
    logic [1:0]  al;
    logic        me;
    logic [4:0]  dc;
    logic [15:0] db;
    logic [1:0]  dl;
    int          len [6];
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t tbl [5];
  vec_t abv;

  qspi_phase_if #(
    .DLEN_W (DLEN_W),
    .DUMMY_W(DUMMY_W),
    .BCNT_W (BCNT_W)
  ) bus ();

  qspi_phase_sequencer #(
    .DLEN_W (DLEN_W),
    .DUMMY_W(DUMMY_W),
    .BCNT_W (BCNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic xip, input logic [1:0] cl,
    input logic [2:0] ab, input logic [1:0] al,
    input logic me, input logic [4:0] dc,
    input logic [15:0] db, input logic [1:0] dl,
    input int l1, input int l2, input int l3,
    input int l4, input int l5
  );
    vec_t v;
    v.xip = xip; v.cl = cl; v.ab = ab; v.al = al;
    v.me = me; v.dc = dc; v.db = db; v.dl = dl;
    v.len[0] = 0; v.len[1] = l1; v.len[2] = l2;
    v.len[3] = l3; v.len[4] = l4; v.len[5] = l5;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input vec_t v);
    bus.xip_mode     = v.xip;
    bus.cmd_lanes    = v.cl;
    bus.addr_bytes   = v.ab;
    bus.addr_lanes   = v.al;
    bus.mode_en      = v.me;
    bus.dummy_cycles = v.dc;
    bus.data_bytes   = v.db;
    bus.data_lanes   = v.dl;
  endtask

  task automatic drive_junk();
    bus.xip_mode     = ~bus.xip_mode;
    bus.cmd_lanes    = ~bus.cmd_lanes;
    bus.addr_bytes   = 3'd7;
    bus.addr_lanes   = ~bus.addr_lanes;
    bus.mode_en      = ~bus.mode_en;
    bus.dummy_cycles = 5'd31;
    bus.data_bytes   = 16'hffff;
    bus.data_lanes   = ~bus.data_lanes;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " phase"}, 32'(bus.phase), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " beat_cnt"}, 32'(bus.beat_cnt), 0);
    chk({tag, " phase_start"}, 32'(bus.phase_start), 0);
    chk({tag, " last_beat"}, 32'(bus.last_beat), 0);
  endtask

  // Starts a transfer from IDLE and walks it to done, one beat_en
  // every 'period' cycles; ends on the done cycle.
  task automatic run_xfer(input int id, input vec_t v,
                          input int period, input bit noisy);
    bit    any;
    string t;
    any = 1'b0;
    for (int p = 1; p <= 5; p++)
      if (v.len[p] > 0) any = 1'b1;
    drive_cfg(v);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    drive_junk();
    if (!any) begin
      t = $sformatf("x%0d empty", id);
      chk({t, " done"}, 32'(bus.done), 1);
      chk_idle(t);
      step();
      chk({t, " done 2nd"}, 32'(bus.done), 0);
      chk({t, " busy 2nd"}, 32'(bus.busy), 0);
      return;
    end
    chk($sformatf("x%0d done early", id), 32'(bus.done), 0);
    for (int p = 1; p <= 5; p++) begin
      for (int b = 0; b < v.len[p]; b++) begin
        for (int g = 0; g < period; g++) begin
          t = $sformatf("x%0d p%0d b%0d g%0d", id, p, b, g);
          bus.start   = noisy;
          bus.beat_en = (g == period - 1);
          chk({t, " phase"}, 32'(bus.phase), 32'(p));
          chk({t, " beat_cnt"}, 32'(bus.beat_cnt), 32'(b));
          chk({t, " phase_start"}, 32'(bus.phase_start),
              32'(b == 0 && g == 0));
          chk({t, " last_beat"}, 32'(bus.last_beat),
              32'(b == v.len[p] - 1));
          chk({t, " busy"}, 32'(bus.busy), 1);
          chk({t, " done"}, 32'(bus.done), 0);
          step();
        end
      end
    end
    bus.start   = 1'b0;
    bus.beat_en = 1'b0;
    t = $sformatf("x%0d end", id);
    chk({t, " done"}, 32'(bus.done), 1);
    chk({t, " aborted"}, 32'(bus.aborted), 0);
    chk_idle(t);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    tbl[0] = mk(0, 2'b00, 3, 2'b10, 1, 4, 2, 2'b10,
                8, 6, 2, 4, 4);
    tbl[1] = mk(1, 2'b00, 4, 2'b00, 0, 0, 1, 2'b01,
                0, 32, 0, 0, 4);
    tbl[2] = mk(1, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00,
                0, 0, 0, 0, 0);
    tbl[3] = mk(0, 2'b01, 7, 2'b01, 1, 31, 3, 2'b11,
                4, 16, 4, 31, 6);
    tbl[4] = mk(0, 2'b11, 1, 2'b00, 0, 0, 0, 2'b00,
                2, 8, 0, 0, 0);
    abv    = mk(1, 2'b00, 0, 2'b00, 0, 0, 2, 2'b00,
                0, 0, 0, 0, 16);

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.beat_en = 1'b0;
    bus.abort   = 1'b0;
    drive_cfg(tbl[0]);
    step();
    step();
    chk_idle("reset");
    chk("reset done", 32'(bus.done), 0);
    chk("reset aborted", 32'(bus.aborted), 0);
    rst = 1'b0;
    step();

    bus.beat_en = 1'b1;
    bus.abort   = 1'b1;
    step();
    bus.beat_en = 1'b0;
    bus.abort   = 1'b0;
    chk_idle("idle ignore");
    chk("idle ignore aborted", 32'(bus.aborted), 0);
    chk("idle ignore done", 32'(bus.done), 0);

    run_xfer(0, tbl[0], 1, 1'b0);
    run_xfer(1, tbl[1], 1, 1'b0);
    run_xfer(2, tbl[2], 1, 1'b0);
    run_xfer(3, tbl[0], 3, 1'b0);
    run_xfer(4, tbl[3], 1, 1'b1);
    run_xfer(5, tbl[4], 2, 1'b1);

    drive_cfg(abv);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ab phase", 32'(bus.phase), 5);
    chk("ab phase_start", 32'(bus.phase_start), 1);
    bus.beat_en = 1'b1;
    repeat (5) step();
    chk("ab pre phase", 32'(bus.phase), 5);
    chk("ab pre beat_cnt", 32'(bus.beat_cnt), 5);
    bus.abort = 1'b1;
    step();
    bus.abort   = 1'b0;
    bus.beat_en = 1'b0;
    chk_idle("ab post");
    chk("ab post aborted", 32'(bus.aborted), 1);
    chk("ab post done", 32'(bus.done), 0);
    step();
    chk("ab pulse end", 32'(bus.aborted), 0);
    run_xfer(6, tbl[1], 1, 1'b0);

    drive_cfg(tbl[1]);
    bus.start = 1'b1;
    step();
    bus.start   = 1'b0;
    bus.beat_en = 1'b1;
    repeat (3) step();
    bus.beat_en = 1'b0;
    chk("rst pre phase", 32'(bus.phase), 2);
    chk("rst pre beat_cnt", 32'(bus.beat_cnt), 3);
    #3;
    rst = 1'b1;
    #1;
    chk_idle("rst async");
    chk("rst async done", 32'(bus.done), 0);
    chk("rst async aborted", 32'(bus.aborted), 0);
    #1;
    rst = 1'b0;
    step();
    chk_idle("rst after");
    chk("rst after done", 32'(bus.done), 0);
    chk("rst after aborted", 32'(bus.aborted), 0);
    run_xfer(7, tbl[0], 1, 1'b0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
